// File: rtl/sha256_msg_sched_if.sv
// rtl/sha256_msg_sched_if.sv - handshake/status bundle between host, scheduler and compression stage
//
// Signals:
//   start_in        host -> scheduler  one-cycle block start request
//   word_in         host -> scheduler  message word (word 0 first)
//   word_valid_in   host -> scheduler  word_in valid
//   word_ready_out  scheduler -> host  scheduler accepts a word this cycle
//   mc_start_out    scheduler -> comp  load-initial-hash strobe
//   w_out           scheduler -> comp  schedule word W_t
//   round_out       scheduler -> comp  round index t
//   state_out       scheduler -> comp  00 idle/init, 01 round 0..62, 10 round 63, 11 hold
//   done_out        scheduler -> comp  one-cycle pulse after round 63
// Modports: slave = scheduler side, master = host/driver side.

interface sha256_msg_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_in;
    logic [DATA_WIDTH-1:0] word_in;
    logic                  word_valid_in;
    logic                  word_ready_out;
    logic                  mc_start_out;
    logic [DATA_WIDTH-1:0] w_out;
    logic [5:0]            round_out;
    logic [1:0]            state_out;
    logic                  done_out;

    modport slave (
        input  start_in,
        input  word_in,
        input  word_valid_in,
        output word_ready_out,
        output mc_start_out,
        output w_out,
        output round_out,
        output state_out,
        output done_out
    );

    modport master (
        output start_in,
        output word_in,
        output word_valid_in,
        input  word_ready_out,
        input  mc_start_out,
        input  w_out,
        input  round_out,
        input  state_out,
        input  done_out
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message scheduler streaming W0..W63 to the compression stage
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   sha256_msg_sched_if.slave (start/word handshake in, schedule/status out)
// Optional feature: define SHA256_MSG_BYTESWAP_EN to byte-reverse each accepted
// word before storage (little-endian hosts). Default build stores words unchanged.
// All outputs are decoded from registered state only.

module sha256_msg_sched #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    sha256_msg_sched_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_INIT = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [5:0]            r_round;
    logic [DATA_WIDTH-1:0] r_win [16];

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_word_store;
    logic [DATA_WIDTH-1:0] w_new_word;

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                   input int unsigned n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sig0(input logic [DATA_WIDTH-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sig1(input logic [DATA_WIDTH-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Ready is a pure state decode, so accept never depends combinationally on an output.
    assign w_accept = (r_state == S_LOAD) && bus.word_valid_in;

`ifdef SHA256_MSG_BYTESWAP_EN
    assign w_word_store = {bus.word_in[7:0], bus.word_in[15:8],
                           bus.word_in[23:16], bus.word_in[31:24]};
`else
    assign w_word_store = bus.word_in;
`endif

    // Slot 0 holds W_t, so W_{t+16} needs slots 14, 9, 1 and 0.
    assign w_new_word = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start_in) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept && (r_cnt == 4'd15)) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_round == 6'd63) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_round <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_in) begin
                        r_cnt <= 4'd0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_win[r_cnt] <= w_word_store;
                        r_cnt        <= r_cnt + 4'd1;
                    end
                end
                S_INIT: begin
                    r_round <= 6'd0;
                end
                S_RUN: begin
                    for (int i = 0; i < 15; i++) begin
                        r_win[i] <= r_win[i+1];
                    end
                    r_win[15] <= w_new_word;
                    // Wraps to 0 after round 63, leaving the counter clean for the next block.
                    r_round   <= r_round + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.word_ready_out = (r_state == S_LOAD);
    assign bus.mc_start_out   = (r_state == S_INIT);
    assign bus.done_out       = (r_state == S_DONE);
    assign bus.w_out          = (r_state == S_RUN) ? r_win[0] : '0;
    assign bus.round_out      = (r_state == S_RUN) ? r_round : 6'd0;

    always_comb begin
        bus.state_out = 2'b00;
        case (r_state)
            S_RUN:   bus.state_out = (r_round == 6'd63) ? 2'b10 : 2'b01;
            S_DONE:  bus.state_out = 2'b11;
            default: bus.state_out = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - randomized self-checking bench for sha256_msg_sched

module tb_sha256_msg_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sha256_msg_sched_if #(.DATA_WIDTH(32)) bus ();

    sha256_msg_sched #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_bad    = 0;

    logic [31:0] blk [16];
    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] host_form(input logic [31:0] x);
`ifdef SHA256_MSG_BYTESWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    // Reference: the full 64-word schedule from the textbook recurrence.
    task automatic build_expected();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = blk[t];
            end else begin
                exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                         + exp_w[t-7]
                         + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                         + exp_w[t-16];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: valid always high; 1: toggle 1/0; 2: random gaps.
    // abort_at >= 0 asserts rst during that round.
    task automatic run_block(input int mode, input int abort_at, input bit pulse30);
        int idx;
        int cyc;
        bit v;
        build_expected();

        // Idle with junk on the word bus: must not leave IDLE.
        for (int k = 0; k < 2; k++) begin
            bus.word_valid_in = 1'b1;
            bus.word_in       = $urandom;
            tick();
            check_eq("idle_ready", {31'd0, bus.word_ready_out}, 32'd0);
        end

        bus.start_in      = 1'b1;
        bus.word_valid_in = 1'b0;
        tick();
        bus.start_in = 1'b0;

        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 400) begin
            check_eq("load_ready", {31'd0, bus.word_ready_out}, 32'd1);
            check_eq("load_mcstart", {31'd0, bus.mc_start_out}, 32'd0);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.word_valid_in = v;
            bus.word_in       = v ? host_form(blk[idx]) : $urandom;
            tick();
            if (v) idx++;
            cyc++;
        end
        check_eq("load_count", idx, 16);
        if (mode == 1) check_eq("toggle_cycles", cyc, 31);
        bus.word_valid_in = 1'b0;

        check_eq("init_mcstart", {31'd0, bus.mc_start_out}, 32'd1);
        check_eq("init_state", {30'd0, bus.state_out}, 32'd0);
        check_eq("init_ready", {31'd0, bus.word_ready_out}, 32'd0);
        tick();

        for (int t = 0; t < 64; t++) begin
            obs_w[t] = bus.w_out;
            check_eq($sformatf("w%0d", t), bus.w_out, exp_w[t]);
            check_eq($sformatf("round%0d", t), {26'd0, bus.round_out}, t);
            check_eq($sformatf("state%0d", t), {30'd0, bus.state_out}, (t < 63) ? 32'd1 : 32'd2);
            check_eq("run_flags", {29'd0, bus.word_ready_out, bus.mc_start_out, bus.done_out}, 32'd0);
            if (t == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_eq("rst_state", {30'd0, bus.state_out}, 32'd0);
                check_eq("rst_round", {26'd0, bus.round_out}, 32'd0);
                check_eq("rst_w", bus.w_out, 32'd0);
                check_eq("rst_ready", {31'd0, bus.word_ready_out}, 32'd0);
                return;
            end
            bus.word_valid_in = 1'b1;
            bus.word_in       = $urandom;
            bus.start_in      = pulse30 && (t == 30);
            tick();
        end
        bus.word_valid_in = 1'b0;
        bus.start_in      = 1'b0;

        check_eq("done_state", {30'd0, bus.state_out}, 32'd3);
        check_eq("done_pulse", {31'd0, bus.done_out}, 32'd1);
        check_eq("done_w", bus.w_out, 32'd0);
        check_eq("done_round", {26'd0, bus.round_out}, 32'd0);
        bus.start_in = 1'b1;            // ignored in DONE
        tick();
        bus.start_in = 1'b0;
        check_eq("post_done", {31'd0, bus.done_out}, 32'd0);
        check_eq("post_state", {30'd0, bus.state_out}, 32'd0);
        tick();
        check_eq("post_ready", {31'd0, bus.word_ready_out}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_in      = 1'b0;
        bus.word_in       = '0;
        bus.word_valid_in = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_eq("reset_ready", {31'd0, bus.word_ready_out}, 32'd0);
        check_eq("reset_mcstart", {31'd0, bus.mc_start_out}, 32'd0);
        check_eq("reset_w", bus.w_out, 32'd0);
        check_eq("reset_round", {26'd0, bus.round_out}, 32'd0);
        check_eq("reset_state", {30'd0, bus.state_out}, 32'd0);
        check_eq("reset_done", {31'd0, bus.done_out}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        run_block(0, 20, 1'b0);

        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        run_block(0, -1, 1'b0);
        check_eq("abc_w0", obs_w[0], 32'h61626380);
        check_eq("abc_w15", obs_w[15], 32'h00000018);
        check_eq("abc_w16", obs_w[16], 32'h61626380);
        check_eq("abc_w17", obs_w[17], 32'h000F0000);

        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        run_block(1, -1, 1'b0);

        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        run_block(2, -1, 1'b1);

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            run_block(2, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
